fifo_rd_sched: RTL and testbench

Read-side scheduler for the two-cycle-latency single-port FIFO (pop in cycle t, rdata/valid registered and visible in cycle t+2). It turns the FIFO's pop/valid interface into a streaming valid/ready source with back-pressure. Pops are issued only when a slot is reserved in an internal skid buffer, so no returned word is ever dropped. It sits between the FIFO and any downstream consumer that can stall.

---
 rtl/fifo_rd_sched.sv | 148 ++++++++++++++
 tb/tb_fifo_rd_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_rd_sched                                                  |
// | Purpose  : Read-side scheduler turning a 2-cycle-latency FIFO pop/valid  |
// |            interface into a valid/ready stream via a credit-reserved     |
// |            skid buffer.                                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_rd_sched #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       fifo_empty,
  input  logic                       fifo_valid,
  input  logic [WIDTH-1:0]           fifo_rdata,
  output logic                       fifo_pop,
  output logic                       fifo_flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       proto_err
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_occ_w = $clog2(DEPTH) + 1;
  localparam logic [c_occ_w-1:0] c_depth = c_occ_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  generate
    if (LAT != 2) begin : g_lat_check
      $error("fifo_rd_sched: LAT must be 2");
    end
    if (DEPTH < 1) begin : g_depth_check
      $error("fifo_rd_sched: DEPTH must be at least 1");
    end
  endgenerate

  logic [1:0]         r_pop_d;
  logic [c_occ_w-1:0] r_occ;
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic               r_proto_err;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic [1:0]         w_pop_d_nxt;
  logic [c_occ_w-1:0] w_occ_nxt;
  logic [c_ptr_w-1:0] w_wptr_nxt;
  logic [c_ptr_w-1:0] w_rptr_nxt;
  logic               w_proto_err_nxt;
  logic [c_occ_w:0]   w_committed;
  logic               w_cap;
  logic               w_hs;
  logic               w_full;
  logic               w_wr;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  // Credits: buffered words plus responses still on their way back.
  assign w_committed = {1'b0, r_occ} + (c_occ_w + 1)'(r_pop_d[0])
                                     + (c_occ_w + 1)'(r_pop_d[1]);

  // Gated by rst_n so no pop escapes while the response tracker is held clear.
  assign w_pop = rst_n & en & ~flush & ~fifo_empty
               & (w_committed < {1'b0, c_depth});

  assign w_cap  = fifo_valid & ~flush;
  assign w_hs   = out_valid & out_ready;
  assign w_full = (r_occ == c_depth);
  assign w_wr   = w_cap & (~w_full | w_hs);

  assign fifo_pop   = w_pop;
  assign fifo_flush = flush;
  assign out_valid  = (r_occ != '0);
  assign out_data   = r_mem[r_rptr];
  assign occ        = r_occ;
  assign proto_err  = r_proto_err;

  always_comb begin
    w_pop_d_nxt     = {r_pop_d[0], w_pop};
    w_occ_nxt       = r_occ;
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_proto_err_nxt = r_proto_err;

    if (w_wr) begin
      w_wptr_nxt = f_inc(r_wptr);
    end
    if (w_hs) begin
      w_rptr_nxt = f_inc(r_rptr);
    end
    case ({w_wr, w_hs})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase

    // Responses must line up exactly with pops issued two cycles earlier.
    if (!flush) begin
      if ((fifo_valid ^ r_pop_d[1]) || (w_cap && w_full && !w_hs)) begin
        w_proto_err_nxt = 1'b1;
      end
    end

    if (flush) begin
      w_pop_d_nxt = 2'b00;
      w_occ_nxt   = '0;
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_d     <= 2'b00;
      r_occ       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_pop_d     <= w_pop_d_nxt;
      r_occ       <= w_occ_nxt;
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_proto_err <= w_proto_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[r_wptr] <= fifo_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_rd_sched                                               |
// | Purpose  : Self-checking bench for fifo_rd_sched with a 2-cycle FIFO     |
// |            model and an expected-data scoreboard.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_sched;

  localparam int c_width = 16;
  localparam int c_depth = 4;

  logic               clk;
  logic               rst_n;
  logic               en;
  logic               flush;
  logic               fifo_empty;
  logic               fifo_valid;
  logic [c_width-1:0] fifo_rdata;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               out_valid;
  logic               out_ready;
  logic [c_width-1:0] out_data;
  logic [2:0]         occ;
  logic               proto_err;

  fifo_rd_sched #(.WIDTH(c_width), .DEPTH(c_depth), .LAT(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_valid (fifo_valid),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .fifo_flush (fifo_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occ        (occ),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle-latency FIFO model
  logic [c_width-1:0] r_fmem [256];
  logic [7:0]         r_rd_idx;
  logic [7:0]         wr_idx;
  logic               r_st1_v, r_st2_v;
  logic [c_width-1:0] r_st1_d, r_st2_d;
  logic               inj;

  assign fifo_empty = (r_rd_idx == wr_idx);
  assign fifo_valid = r_st2_v | inj;
  assign fifo_rdata = r_st2_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st1_v  <= 1'b0;
      r_st2_v  <= 1'b0;
      r_st1_d  <= '0;
      r_st2_d  <= '0;
      r_rd_idx <= wr_idx;
    end else if (fifo_flush) begin
      r_st1_v  <= 1'b0;
      r_st2_v  <= 1'b0;
      r_rd_idx <= wr_idx;
    end else begin
      r_st2_v <= r_st1_v;
      r_st2_d <= r_st1_d;
      r_st1_v <= fifo_pop;
      r_st1_d <= r_fmem[r_rd_idx];
      if (fifo_pop) r_rd_idx <= r_rd_idx + 8'd1;
    end
  end

  logic [c_width-1:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [c_width-1:0] v);
    r_fmem[wr_idx] = v;
    wr_idx = wr_idx + 8'd1;
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; inj = 1'b0; out_ready = 1'b0;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // Scoreboard consumer: every delivered word must match the next expected one
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
      else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int npop, first_pop, last_pop, nov, first_ov, last_ov, nbad;
    bit hit;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; out_ready = 1'b0; inj = 1'b0; wr_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_occ", 32'(occ), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_fifo_pop", 32'(fifo_pop), 32'd0);
    step();
    rst_n = 1'b1;

    // Full-rate stream
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    en = 1'b1; out_ready = 1'b1;
    npop = 0; first_pop = -1; last_pop = -1; nov = 0; first_ov = -1; last_ov = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_pop) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i; npop++;
      end
      if (out_valid) begin
        if (first_ov < 0) first_ov = i;
        last_ov = i; nov++;
      end
    end
    check("fr_npop", 32'(npop), 32'd8);
    check("fr_pop_span", 32'(last_pop - first_pop), 32'd7);
    check("fr_latency", 32'(first_ov - first_pop), 32'd3);
    check("fr_nvalid", 32'(nov), 32'd8);
    check("fr_valid_span", 32'(last_ov - first_ov), 32'd7);
    check("fr_proto_err", 32'(proto_err), 32'd0);
    check("fr_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    en = 1'b1;
    npop = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_pop) npop++;
    end
    check("bp_npop", 32'(npop), 32'd4);
    check("bp_occ", 32'(occ), 32'd4);
    check("bp_pop_idle", 32'(fifo_pop), 32'd0);
    check("bp_hold_data", 32'(out_data), 32'h0001);
    step();
    out_ready = 1'b1;
    repeat (25) @(negedge clk);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_occ_end", 32'(occ), 32'd0);
    check("bp_proto_err", 32'(proto_err), 32'd0);

    // Empty FIFO
    do_reset();
    en = 1'b1;
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_pop || out_valid || occ != 3'd0) nbad++;
      check("empty_pop", 32'(fifo_pop), 32'd0);
    end
    check("empty_occ", 32'(occ), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);

    // Flush with two in flight and occ=2
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(16'(16'h0010 + i));
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (occ == 3'd2) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("flush_wait_timeout", 32'(occ), 32'd2);
    flush = 1'b1;
    @(negedge clk);
    check("flush_out", 32'(fifo_flush), 32'd1);
    check("flush_no_pop", 32'(fifo_pop), 32'd0);
    step();
    flush = 1'b0;
    exp_q.delete();
    check("flush_occ", 32'(occ), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    nov = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) nov++;
    end
    check("flush_no_stale", 32'(nov), 32'd0);
    step();
    out_ready = 1'b1;
    push_word(16'h00A1);
    push_word(16'h00A2);
    repeat (10) @(negedge clk);
    check("flush_new_drained", 32'(exp_q.size()), 32'd0);
    check("flush_proto_err", 32'(proto_err), 32'd0);

    // Protocol error: response with no matching pop
    do_reset();
    step();
    inj = 1'b1;
    @(negedge clk);
    check("perr_before", 32'(proto_err), 32'd0);
    step();
    inj = 1'b0;
    check("perr_set", 32'(proto_err), 32'd1);
    repeat (5) @(negedge clk);
    check("perr_sticky", 32'(proto_err), 32'd1);
    do_reset();
    @(negedge clk);
    check("perr_cleared", 32'(proto_err), 32'd0);

    // Asynchronous reset mid-stream at occ=3
    step();
    for (int i = 1; i <= 8; i++) push_word(16'(16'h0100 + i));
    en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (occ == 3'd3) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("ares_wait_timeout", 32'(occ), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ares_valid", 32'(out_valid), 32'd0);
    check("ares_occ", 32'(occ), 32'd0);
    check("ares_pop", 32'(fifo_pop), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("ares_after_occ", 32'(occ), 32'd0);
    check("ares_after_perr", 32'(proto_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
